// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU operation codes, RV32I opcodes and decoded-entry layout
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [3:0]  func;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        src1_pc;
        logic        src1_zero;
        logic        src2_imm;
        logic        we;
        logic [31:0] pc;
        logic        illegal;
    } dec_t;

    // alt selects the subtract / arithmetic-shift variant where one exists
    function automatic logic [3:0] alu_func(input logic alt, input logic [2:0] funct3);
        logic [3:0] f;
        case (funct3)
            3'b000:  f = alt ? ALU_SUB : ALU_ADD;
            3'b001:  f = ALU_SLL;
            3'b010:  f = ALU_SLT;
            3'b011:  f = ALU_SLTU;
            3'b100:  f = ALU_XOR;
            3'b101:  f = alt ? ALU_SRA : ALU_SRL;
            3'b110:  f = ALU_OR;
            default: f = ALU_AND;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - I-type, shift-amount and U-type immediates from instr[31:12]
module imm_gen (
    input  logic [19:0] upper_i,
    output logic [31:0] imm_i_o,
    output logic [31:0] imm_sh_o,
    output logic [31:0] imm_u_o
);

    // upper_i[k] is instr[k+12]
    assign imm_i_o  = {{20{upper_i[19]}}, upper_i[19:8]};
    assign imm_sh_o = {27'b0, upper_i[12:8]};
    assign imm_u_o  = {upper_i, 12'b0};

endmodule

// File: rtl/alu_decode.sv
// rtl/alu_decode.sv - RV32I OP/OP-IMM/LUI/AUIPC decode with one-entry output register
module alu_decode
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_func,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic            out_src1_pc,
    output logic            out_src1_zero,
    output logic            out_src2_imm,
    output logic            out_we,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_sh;
    logic [31:0] imm_u;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    imm_gen u_imm_gen (
        .upper_i (in_instr[31:12]),
        .imm_i_o (imm_i),
        .imm_sh_o(imm_sh),
        .imm_u_o (imm_u)
    );

    logic        legal;
    logic [3:0]  func;
    logic [31:0] imm;
    logic        src1_pc;
    logic        src1_zero;
    logic        src2_imm;

    always_comb begin
        legal     = 1'b0;
        func      = ALU_ADD;
        imm       = '0;
        src1_pc   = 1'b0;
        src1_zero = 1'b0;
        src2_imm  = 1'b0;
        case (opcode)
            OPC_OP: begin
                legal = (funct7 == F7_BASE) ||
                        ((funct7 == F7_ALT) && (funct3 == 3'b000 || funct3 == 3'b101));
                func  = alu_func(funct7[5], funct3);
            end
            OPC_OP_IMM: begin
                src2_imm = 1'b1;
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    imm   = imm_sh;
                    legal = (funct7 == F7_BASE) || (funct3 == 3'b101 && funct7 == F7_ALT);
                end else begin
                    imm   = imm_i;
                    legal = 1'b1;
                end
                // only shifts look at instr[30]; ADDI with imm[10] set stays add
                func = alu_func(funct3 == 3'b101 && in_instr[30], funct3);
            end
            OPC_LUI: begin
                legal     = 1'b1;
                imm       = imm_u;
                src1_zero = 1'b1;
                src2_imm  = 1'b1;
            end
            OPC_AUIPC: begin
                legal    = 1'b1;
                imm      = imm_u;
                src1_pc  = 1'b1;
                src2_imm = 1'b1;
            end
            default: ;
        endcase
        if (!legal) begin
            func      = ALU_ADD;
            imm       = '0;
            src1_pc   = 1'b0;
            src1_zero = 1'b0;
            src2_imm  = 1'b0;
        end
    end

    dec_t decoded;

    always_comb begin
        decoded           = '0;
        decoded.func      = func;
        decoded.rs1       = in_instr[19:15];
        decoded.rs2       = in_instr[24:20];
        decoded.rd        = in_instr[11:7];
        decoded.imm       = imm;
        decoded.src1_pc   = src1_pc;
        decoded.src1_zero = src1_zero;
        decoded.src2_imm  = src2_imm;
        decoded.we        = legal && (in_instr[11:7] != 5'd0);
        decoded.pc        = in_pc;
        decoded.illegal   = !legal;
    end

    dec_t entry_q, entry_d;
    logic valid_q, valid_d;
    logic accept;

    assign in_ready = !flush && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        entry_d = accept ? decoded : entry_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            entry_q <= '0;
        end else begin
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_func      = entry_q.func;
    assign out_rs1       = entry_q.rs1;
    assign out_rs2       = entry_q.rs2;
    assign out_rd        = entry_q.rd;
    assign out_imm       = entry_q.imm;
    assign out_src1_pc   = entry_q.src1_pc;
    assign out_src1_zero = entry_q.src1_zero;
    assign out_src2_imm  = entry_q.src2_imm;
    assign out_we        = entry_q.we;
    assign out_pc        = entry_q.pc;
    assign out_illegal   = entry_q.illegal;

endmodule

// File: tb/tb_alu_decode.sv
// tb/tb_alu_decode.sv - scoreboard bench for alu_decode
module tb_alu_decode;

    typedef struct packed {
        logic [3:0]  func;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        src1_pc;
        logic        src1_zero;
        logic        src2_imm;
        logic        we;
        logic [31:0] pc;
        logic        illegal;
    } exp_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [3:0]  func;
        logic [31:0] imm;
        logic        ill;
        logic        we;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_func;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [31:0] out_imm;
    logic        out_src1_pc;
    logic        out_src1_zero;
    logic        out_src2_imm;
    logic        out_we;
    logic [31:0] out_pc;
    logic        out_illegal;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    alu_decode #(.XLEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_func     (out_func),
        .out_rs1      (out_rs1),
        .out_rs2      (out_rs2),
        .out_rd       (out_rd),
        .out_imm      (out_imm),
        .out_src1_pc  (out_src1_pc),
        .out_src1_zero(out_src1_zero),
        .out_src2_imm (out_src2_imm),
        .out_we       (out_we),
        .out_pc       (out_pc),
        .out_illegal  (out_illegal)
    );

    function automatic exp_t observe();
        exp_t e;
        e.func      = out_func;
        e.rs1       = out_rs1;
        e.rs2       = out_rs2;
        e.rd        = out_rd;
        e.imm       = out_imm;
        e.src1_pc   = out_src1_pc;
        e.src1_zero = out_src1_zero;
        e.src2_imm  = out_src2_imm;
        e.we        = out_we;
        e.pc        = out_pc;
        e.illegal   = out_illegal;
        return e;
    endfunction

    // Reference decode written per mnemonic
    function automatic exp_t exp_decode(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        logic ok;
        logic [2:0] f3;
        logic [6:0] f7;
        e     = '0;
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.rd  = ins[11:7];
        e.pc  = pc;
        f3    = ins[14:12];
        f7    = ins[31:25];
        ok    = 1'b0;
        if (ins[6:0] == 7'h33) begin
            ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            e.func = {f7 == 7'h20, f3};
        end else if (ins[6:0] == 7'h13) begin
            e.src2_imm = 1'b1;
            if (f3 == 3'd1) begin
                ok = (f7 == 7'h00); e.imm = {27'd0, ins[24:20]}; e.func = 4'h1;
            end else if (f3 == 3'd5) begin
                ok = (f7 == 7'h00) || (f7 == 7'h20); e.imm = {27'd0, ins[24:20]};
                e.func = (f7 == 7'h20) ? 4'hD : 4'h5;
            end else begin
                ok = 1'b1; e.imm = {{20{ins[31]}}, ins[31:20]}; e.func = {1'b0, f3};
            end
        end else if (ins[6:0] == 7'h37 || ins[6:0] == 7'h17) begin
            ok = 1'b1; e.func = 4'h0; e.imm = {ins[31:12], 12'h000}; e.src2_imm = 1'b1;
            e.src1_zero = (ins[6:0] == 7'h37);
            e.src1_pc   = (ins[6:0] == 7'h17);
        end
        if (!ok) begin
            e.func = 4'h0; e.imm = '0; e.src1_pc = 1'b0; e.src1_zero = 1'b0; e.src2_imm = 1'b0;
        end
        e.illegal = !ok;
        e.we      = ok && (ins[11:7] != 5'd0);
        return e;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (observe() !== exp_t'(0)) begin
            n_bad++; $display("FAIL reset_payload: got %h want 0", observe());
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        exp_t got, exp;
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h100;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL add_in_ready: got %b want 1", in_ready);
        end
        q.push_back(exp_decode(in_instr, in_pc));
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_bad++; $display("FAIL add_valid: got %b want 1", out_valid);
        end
        got = observe();
        exp = q.pop_front();
        n_cmp++;
        if (got !== exp) begin
            n_bad++; $display("FAIL add_entry: got %h want %h", got, exp);
        end
        n_cmp++;
        if ({out_func, out_rs1, out_rs2, out_rd, out_src2_imm, out_we, out_illegal, out_pc}
            !== {4'h0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 32'h100}) begin
            n_bad++; $display("FAIL add_fields: got %h/%0d/%0d/%0d/%b/%b/%b/%h want 0/1/2/3/0/1/0/100",
                out_func, out_rs1, out_rs2, out_rd, out_src2_imm, out_we, out_illegal, out_pc);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL add_drain: got %b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        exp_t got, exp;
        vec_t v[10] = '{
            '{32'h402081B3, 4'h8, 32'h00000000, 1'b0, 1'b1},
            '{32'hFFF00293, 4'h0, 32'hFFFFFFFF, 1'b0, 1'b1},
            '{32'h4043D313, 4'hD, 32'h00000004, 1'b0, 1'b1},
            '{32'h123450B7, 4'h0, 32'h12345000, 1'b0, 1'b1},
            '{32'h12345097, 4'h0, 32'h12345000, 1'b0, 1'b1},
            '{32'h40000093, 4'h0, 32'h00000400, 1'b0, 1'b1},
            '{32'h00315093, 4'h5, 32'h00000003, 1'b0, 1'b1},
            '{32'hFFB13093, 4'h3, 32'hFFFFFFFB, 1'b0, 1'b1},
            '{32'h4020D1B3, 4'hD, 32'h00000000, 1'b0, 1'b1},
            '{32'h40311093, 4'h0, 32'h00000000, 1'b1, 1'b0}
        };
        out_ready = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            if (i > 0) begin
                n_cmp++;
                if (out_valid !== 1'b1) begin
                    n_bad++; $display("FAIL b2b_valid[%0d]: got %b want 1", i - 1, out_valid);
                end
                got = observe();
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++; $display("FAIL b2b_queue[%0d]: got empty want entry", i - 1);
                end else begin
                    exp = q.pop_front();
                    if (got !== exp) begin
                        n_bad++; $display("FAIL b2b_entry[%0d]: got %h want %h", i - 1, got, exp);
                    end
                end
                n_cmp++;
                if ({out_func, out_imm, out_illegal, out_we}
                    !== {v[i-1].func, v[i-1].imm, v[i-1].ill, v[i-1].we}) begin
                    n_bad++; $display("FAIL b2b_fields[%0d]: got %h/%h/%b/%b want %h/%h/%b/%b", i - 1,
                        out_func, out_imm, out_illegal, out_we,
                        v[i-1].func, v[i-1].imm, v[i-1].ill, v[i-1].we);
                end
            end
            if (i < 10) begin
                in_valid = 1'b1; in_instr = v[i].instr; in_pc = 32'h1000 + 32'(4 * i);
                #1;
                n_cmp++;
                if (in_ready !== 1'b1) begin
                    n_bad++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready);
                end
                q.push_back(exp_decode(in_instr, in_pc));
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal();
        exp_t got, exp;
        vec_t v[3] = '{
            '{32'h00000073, 4'h0, 32'h0, 1'b1, 1'b0},
            '{32'h4020C1B3, 4'h0, 32'h0, 1'b1, 1'b0},
            '{32'h00208033, 4'h0, 32'h0, 1'b0, 1'b0}
        };
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_instr = v[i].instr; in_pc = 32'h2000 + 32'(8 * i);
            q.push_back(exp_decode(in_instr, in_pc));
            @(negedge clk);
            in_valid = 1'b0;
            n_cmp++;
            if (out_valid !== 1'b1) begin
                n_bad++; $display("FAIL illegal_valid[%0d]: got %b want 1", i, out_valid);
            end
            got = observe();
            exp = q.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_bad++; $display("FAIL illegal_entry[%0d]: got %h want %h", i, got, exp);
            end
            n_cmp++;
            if ({out_func, out_imm, out_illegal, out_we, out_src2_imm}
                !== {v[i].func, v[i].imm, v[i].ill, v[i].we, 1'b0}) begin
                n_bad++; $display("FAIL illegal_fields[%0d]: got %h/%h/%b/%b want %h/%h/%b/%b", i,
                    out_func, out_imm, out_illegal, out_we, v[i].func, v[i].imm, v[i].ill, v[i].we);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        exp_t got, exp;
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h3000;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL bp_first_ready: got %b want 1", in_ready);
        end
        q.push_back(exp_decode(in_instr, in_pc));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            in_instr = 32'h00315093; in_pc = 32'h3004;
            n_cmp++;
            if (out_valid !== 1'b1 || observe() !== q[0]) begin
                n_bad++; $display("FAIL bp_hold[%0d]: got %b/%h want 1/%h", c, out_valid, observe(), q[0]);
            end
            #1;
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, in_ready);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        got = observe();
        exp = q.pop_front();
        n_cmp++;
        if (got !== exp) begin
            n_bad++; $display("FAIL bp_release_entry: got %h want %h", got, exp);
        end
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL bp_release_ready: got %b want 1", in_ready);
        end
        q.push_back(exp_decode(in_instr, in_pc));
        @(negedge clk);
        in_valid = 1'b0;
        got = observe();
        exp = q.pop_front();
        n_cmp++;
        if (out_valid !== 1'b1 || got !== exp) begin
            n_bad++; $display("FAIL bp_next_entry: got %b/%h want 1/%h", out_valid, got, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h4000;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_bad++; $display("FAIL flush_load: got %b want 1", out_valid);
        end
        flush = 1'b1; in_instr = 32'h00315093; in_pc = 32'h4004;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++; $display("FAIL flush_in_ready: got %b want 0", in_ready);
        end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL flush_valid: got %b want 0", out_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL flush_no_accept: got %b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_stall();
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h123450B7; in_pc = 32'h5000;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_bad++; $display("FAIL rst_stall_load: got %b want 1", out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || observe() !== exp_t'(0)) begin
            n_bad++; $display("FAIL rst_stall_clear: got %b/%h want 0/0", out_valid, observe());
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL rst_stall_after: got %b want 0", out_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_illegal();
        test_backpressure();
        test_flush();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
